// File: rtl/qdr_port_arbiter_if.sv
// Requester/controller bundle for the QDR port arbiter.
// The environment drives it through master; the arbiter sits on slave.
interface qdr_port_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_BITS  = 18,
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned TAG_DEPTH  = 32
);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [NUM_REQ-1:0]            req_wr_en;
  logic [NUM_REQ*ADDR_BITS-1:0]  req_wr_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data;
  logic [NUM_REQ-1:0]            req_wr_ready;
  logic [NUM_REQ-1:0]            req_rd_en;
  logic [NUM_REQ*ADDR_BITS-1:0]  req_rd_addr;
  logic [NUM_REQ-1:0]            req_rd_ready;
  logic [NUM_REQ-1:0]            rsp_rd_valid;
  logic [DATA_WIDTH-1:0]         rsp_rd_data;
  logic                          ram_wr_en;
  logic [ADDR_BITS-1:0]          ram_wr_addr;
  logic [DATA_WIDTH-1:0]         ram_wr_data;
  logic                          ram_rd_en;
  logic [ADDR_BITS-1:0]          ram_rd_addr;
  logic                          ram_rd_valid;
  logic [DATA_WIDTH-1:0]         ram_rd_data;
  logic [CNT_W-1:0]              rd_outstanding;
  logic                          err_orphan;

  modport master (
    output req_wr_en, req_wr_addr, req_wr_data, req_rd_en, req_rd_addr,
           ram_rd_valid, ram_rd_data,
    input  req_wr_ready, req_rd_ready, rsp_rd_valid, rsp_rd_data,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
           rd_outstanding, err_orphan
  );

  modport slave (
    input  req_wr_en, req_wr_addr, req_wr_data, req_rd_en, req_rd_addr,
           ram_rd_valid, ram_rd_data,
    output req_wr_ready, req_rd_ready, rsp_rd_valid, rsp_rd_data,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
           rd_outstanding, err_orphan
  );
endinterface

// File: rtl/qdr_port_arbiter.sv
// Round-robin sharing of the QDR controller write/read command ports between
// NUM_REQ requesters, with a tag FIFO steering in-order read data to its owner.
module qdr_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_BITS  = 18,
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned TAG_DEPTH  = 32
) (
  input  logic               clk,
  input  logic               rst,
  qdr_port_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned TW    = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = TW + 1;

  // Per-requester views of the flattened request buses
  logic [ADDR_BITS-1:0]  wr_addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] wr_data_a [NUM_REQ];
  logic [ADDR_BITS-1:0]  rd_addr_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign wr_addr_a[i] = bus.req_wr_addr[i*ADDR_BITS +: ADDR_BITS];
    assign wr_data_a[i] = bus.req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign rd_addr_a[i] = bus.req_rd_addr[i*ADDR_BITS +: ADDR_BITS];
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  ram_wr_en_q, ram_wr_en_d, ram_rd_en_q, ram_rd_en_d;
  logic [ADDR_BITS-1:0]  ram_wr_addr_q, ram_wr_addr_d, ram_rd_addr_q, ram_rd_addr_d;
  logic [DATA_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
  logic [NUM_REQ-1:0]    rsp_rd_valid_q, rsp_rd_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rd_data_q, rsp_rd_data_d;
  logic [PTR_W-1:0]      tag_mem_q [TAG_DEPTH];
  logic [PTR_W-1:0]      tag_mem_d [TAG_DEPTH];
  logic [TW-1:0]         tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_orphan_q, err_orphan_d;

  logic [NUM_REQ-1:0]    wr_grant_c, rd_grant_c;
  logic [PTR_W:0]        wr_pick, rd_pick;
  logic                  tag_full, push, pop;

  // First asserted en at or after ptr, wrapping; returns {found, index}
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] en,
                                              input logic [PTR_W-1:0]   ptr);
    logic             found;
    logic [PTR_W-1:0] idx;
    int unsigned      cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && en[PTR_W'(cand)]) begin
        found = 1'b1;
        idx   = PTR_W'(cand);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] g);
    return (32'(g) == NUM_REQ - 1) ? '0 : g + PTR_W'(1);
  endfunction

  always_comb begin : next_state
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    ram_wr_en_d    = 1'b0;
    ram_rd_en_d    = 1'b0;
    ram_wr_addr_d  = ram_wr_addr_q;
    ram_wr_data_d  = ram_wr_data_q;
    ram_rd_addr_d  = ram_rd_addr_q;
    rsp_rd_valid_d = '0;
    rsp_rd_data_d  = rsp_rd_data_q;
    tag_mem_d      = tag_mem_q;
    tag_wptr_d     = tag_wptr_q;
    tag_rptr_d     = tag_rptr_q;
    err_orphan_d   = err_orphan_q;
    wr_grant_c     = '0;
    rd_grant_c     = '0;

    // Full is judged on the registered count, so a same-cycle pop cannot free a slot
    tag_full = (count_q == CNT_W'(TAG_DEPTH));
    wr_pick  = rr_pick(bus.req_wr_en, wr_ptr_q);
    rd_pick  = rr_pick(bus.req_rd_en & {NUM_REQ{~tag_full}}, rd_ptr_q);
    push     = rd_pick[PTR_W];
    pop      = bus.ram_rd_valid && (count_q != '0);

    if (wr_pick[PTR_W]) begin
      wr_grant_c[wr_pick[PTR_W-1:0]] = 1'b1;
      wr_ptr_d      = rr_next(wr_pick[PTR_W-1:0]);
      ram_wr_en_d   = 1'b1;
      ram_wr_addr_d = wr_addr_a[wr_pick[PTR_W-1:0]];
      ram_wr_data_d = wr_data_a[wr_pick[PTR_W-1:0]];
    end

    if (push) begin
      rd_grant_c[rd_pick[PTR_W-1:0]] = 1'b1;
      rd_ptr_d               = rr_next(rd_pick[PTR_W-1:0]);
      ram_rd_en_d            = 1'b1;
      ram_rd_addr_d          = rd_addr_a[rd_pick[PTR_W-1:0]];
      tag_mem_d[tag_wptr_q]  = rd_pick[PTR_W-1:0];
      tag_wptr_d             = tag_wptr_q + TW'(1);
    end

    if (pop) begin
      rsp_rd_valid_d[tag_mem_q[tag_rptr_q]] = 1'b1;
      rsp_rd_data_d = bus.ram_rd_data;
      tag_rptr_d    = tag_rptr_q + TW'(1);
    end else if (bus.ram_rd_valid) begin
      err_orphan_d = 1'b1;
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ram_wr_en_q    <= 1'b0;
      ram_rd_en_q    <= 1'b0;
      ram_wr_addr_q  <= '0;
      ram_wr_data_q  <= '0;
      ram_rd_addr_q  <= '0;
      rsp_rd_valid_q <= '0;
      rsp_rd_data_q  <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
      tag_wptr_q     <= '0;
      tag_rptr_q     <= '0;
      count_q        <= '0;
      err_orphan_q   <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      ram_wr_en_q    <= ram_wr_en_d;
      ram_rd_en_q    <= ram_rd_en_d;
      ram_wr_addr_q  <= ram_wr_addr_d;
      ram_wr_data_q  <= ram_wr_data_d;
      ram_rd_addr_q  <= ram_rd_addr_d;
      rsp_rd_valid_q <= rsp_rd_valid_d;
      rsp_rd_data_q  <= rsp_rd_data_d;
      tag_mem_q      <= tag_mem_d;
      tag_wptr_q     <= tag_wptr_d;
      tag_rptr_q     <= tag_rptr_d;
      count_q        <= count_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  assign bus.req_wr_ready   = wr_grant_c;
  assign bus.req_rd_ready   = rd_grant_c;
  assign bus.ram_wr_en      = ram_wr_en_q;
  assign bus.ram_wr_addr    = ram_wr_addr_q;
  assign bus.ram_wr_data    = ram_wr_data_q;
  assign bus.ram_rd_en      = ram_rd_en_q;
  assign bus.ram_rd_addr    = ram_rd_addr_q;
  assign bus.rsp_rd_valid   = rsp_rd_valid_q;
  assign bus.rsp_rd_data    = rsp_rd_data_q;
  assign bus.rd_outstanding = count_q;
  assign bus.err_orphan     = err_orphan_q;
endmodule

// File: tb/tb_qdr_port_arbiter.sv
// Directed bench for qdr_port_arbiter: arbitration order, read tag routing,
// tag FIFO full, orphan responses and reset with reads in flight.
module tb_qdr_port_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AB = 18;
  localparam int unsigned DW = 144;
  localparam int unsigned TD = 32;
  localparam int unsigned CW = $clog2(TD) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qdr_port_arbiter_if #(.NUM_REQ(NR), .ADDR_BITS(AB), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) bus ();

  qdr_port_arbiter #(.NUM_REQ(NR), .ADDR_BITS(AB), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [NR-1:0] wr_en, rd_en;
  logic [AB-1:0] wr_addr [NR];
  logic [AB-1:0] rd_addr [NR];
  logic [DW-1:0] wr_data [NR];
  logic          ram_rd_valid;
  logic [DW-1:0] ram_rd_data;

  assign bus.req_wr_en    = wr_en;
  assign bus.req_rd_en    = rd_en;
  assign bus.ram_rd_valid = ram_rd_valid;
  assign bus.ram_rd_data  = ram_rd_data;
  for (genvar i = 0; i < NR; i++) begin : g_pack
    assign bus.req_wr_addr[i*AB +: AB] = wr_addr[i];
    assign bus.req_wr_data[i*DW +: DW] = wr_data[i];
    assign bus.req_rd_addr[i*AB +: AB] = rd_addr[i];
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    wr_en = '0; rd_en = '0; ram_rd_valid = 1'b0; ram_rd_data = '0;
    for (int i = 0; i < NR; i++) begin
      wr_addr[i] = '0; rd_addr[i] = '0; wr_data[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.ram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_ram_wr_en: got %0b exp 0", bus.ram_wr_en); end
    checks++; if (bus.ram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_ram_rd_en: got %0b exp 0", bus.ram_rd_en); end
    checks++; if (bus.rsp_rd_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %0h exp 0", bus.rsp_rd_valid); end
    checks++; if (bus.rd_outstanding !== '0) begin errors++; $display("FAIL reset_outstanding: got %0d exp 0", bus.rd_outstanding); end
    checks++; if (bus.err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan: got %0b exp 0", bus.err_orphan); end
    checks++; if (bus.req_wr_ready !== '0 || bus.req_rd_ready !== '0) begin
      errors++; $display("FAIL reset_ready: got wr %0h rd %0h exp 0", bus.req_wr_ready, bus.req_rd_ready); end
  endtask

  task automatic test_single();
    logic [DW-1:0] pat_a;
    pat_a = {9{16'hA5C3}};
    apply_reset();
    wr_en = 4'b0010; wr_addr[1] = 18'h00010; wr_data[1] = pat_a;
    @(negedge clk);
    checks++; if (bus.req_wr_ready !== 4'b0010) begin errors++; $display("FAIL single_wr_ready: got %0h exp 2", bus.req_wr_ready); end
    tick();
    wr_en = '0;
    checks++; if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 18'h00010 || bus.ram_wr_data !== pat_a) begin
      errors++; $display("FAIL single_wr_cmd: got en %0b addr %0h exp en 1 addr 10", bus.ram_wr_en, bus.ram_wr_addr); end
    tick();
    checks++; if (bus.ram_wr_en !== 1'b0) begin errors++; $display("FAIL single_wr_pulse: got %0b exp 0", bus.ram_wr_en); end
    rd_en = 4'b0010; rd_addr[1] = 18'h00010;
    @(negedge clk);
    checks++; if (bus.req_rd_ready !== 4'b0010) begin errors++; $display("FAIL single_rd_ready: got %0h exp 2", bus.req_rd_ready); end
    tick();
    rd_en = '0;
    checks++; if (bus.ram_rd_en !== 1'b1 || bus.ram_rd_addr !== 18'h00010 || bus.rd_outstanding !== CW'(1)) begin
      errors++; $display("FAIL single_rd_cmd: got en %0b addr %0h out %0d exp 1 10 1", bus.ram_rd_en, bus.ram_rd_addr, bus.rd_outstanding); end
    repeat (7) tick();
    ram_rd_valid = 1'b1; ram_rd_data = pat_a;
    tick();
    ram_rd_valid = 1'b0;
    checks++; if (bus.rsp_rd_valid !== 4'b0010 || bus.rsp_rd_data !== pat_a || bus.rd_outstanding !== '0) begin
      errors++; $display("FAIL single_rsp: got valid %0h out %0d exp valid 2 out 0", bus.rsp_rd_valid, bus.rd_outstanding); end
    tick();
    checks++; if (bus.rsp_rd_valid !== '0 || bus.rsp_rd_data !== pat_a) begin
      errors++; $display("FAIL single_rsp_hold: got valid %0h exp 0 with data held", bus.rsp_rd_valid); end
  endtask

  task automatic test_wr_round_robin();
    int pulses;
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      wr_addr[i] = AB'(32'h100 + i); wr_data[i] = DW'(32'hD0 + i);
    end
    wr_en = 4'hF;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++; if (bus.req_wr_ready !== (NR'(1) << (c % 4))) begin
        errors++; $display("FAIL rr_wr_grant[%0d]: got %0h exp %0h", c, bus.req_wr_ready, NR'(1) << (c % 4)); end
      tick();
      if (bus.ram_wr_en === 1'b1) pulses++;
      checks++; if (bus.ram_wr_addr !== AB'(32'h100 + c % 4) || bus.ram_wr_data !== DW'(32'hD0 + c % 4)) begin
        errors++; $display("FAIL rr_wr_cmd[%0d]: got addr %0h exp %0h", c, bus.ram_wr_addr, 32'h100 + c % 4); end
    end
    wr_en = '0;
    tick();
    checks++; if (bus.ram_wr_en !== 1'b0) begin errors++; $display("FAIL rr_wr_idle: got %0b exp 0", bus.ram_wr_en); end
    checks++; if (pulses != 12) begin errors++; $display("FAIL rr_wr_pulses: got %0d exp 12", pulses); end
  endtask

  task automatic test_rd_interleave();
    int unsigned   seq [4];
    logic [DW-1:0] d [4];
    seq = '{2, 0, 3, 0};
    for (int k = 0; k < 4; k++) d[k] = {9{16'(32'h1000 + k)}};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      rd_en = NR'(1) << seq[k];
      rd_addr[seq[k]] = AB'(32'h200 + k);
      @(negedge clk);
      checks++; if (bus.req_rd_ready !== (NR'(1) << seq[k])) begin
        errors++; $display("FAIL intl_ready[%0d]: got %0h exp %0h", k, bus.req_rd_ready, NR'(1) << seq[k]); end
      tick();
      checks++; if (bus.ram_rd_en !== 1'b1 || bus.ram_rd_addr !== AB'(32'h200 + k)) begin
        errors++; $display("FAIL intl_cmd[%0d]: got en %0b addr %0h exp 1 %0h", k, bus.ram_rd_en, bus.ram_rd_addr, 32'h200 + k); end
    end
    rd_en = '0;
    checks++; if (bus.rd_outstanding !== CW'(4)) begin errors++; $display("FAIL intl_outstanding: got %0d exp 4", bus.rd_outstanding); end
    for (int k = 0; k < 4; k++) begin
      ram_rd_valid = 1'b1; ram_rd_data = d[k];
      tick();
      checks++; if (bus.rsp_rd_valid !== (NR'(1) << seq[k]) || bus.rsp_rd_data !== d[k]) begin
        errors++; $display("FAIL intl_rsp[%0d]: got valid %0h data %0h exp valid %0h", k, bus.rsp_rd_valid, bus.rsp_rd_data[15:0], NR'(1) << seq[k]); end
    end
    ram_rd_valid = 1'b0;
    tick();
    checks++; if (bus.rsp_rd_valid !== '0 || bus.rd_outstanding !== '0) begin
      errors++; $display("FAIL intl_drain: got valid %0h out %0d exp 0 0", bus.rsp_rd_valid, bus.rd_outstanding); end
  endtask

  task automatic test_full();
    int rd_grants, wr_grants;
    logic [DW-1:0] x;
    x = {9{16'h5A5A}};
    apply_reset();
    rd_en = 4'b0010; wr_en = 4'b0100;
    rd_grants = 0; wr_grants = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.req_rd_ready !== '0) rd_grants++;
      if (bus.req_wr_ready === 4'b0100) wr_grants++;
      tick();
    end
    checks++; if (rd_grants != TD) begin errors++; $display("FAIL full_rd_grants: got %0d exp %0d", rd_grants, TD); end
    checks++; if (wr_grants != 40) begin errors++; $display("FAIL full_wr_grants: got %0d exp 40", wr_grants); end
    checks++; if (bus.rd_outstanding !== CW'(TD)) begin errors++; $display("FAIL full_outstanding: got %0d exp %0d", bus.rd_outstanding, TD); end
    ram_rd_valid = 1'b1; ram_rd_data = x;
    @(negedge clk);
    checks++; if (bus.req_rd_ready !== '0) begin errors++; $display("FAIL full_pop_blocks: got %0h exp 0", bus.req_rd_ready); end
    tick();
    ram_rd_valid = 1'b0;
    checks++; if (bus.rd_outstanding !== CW'(TD - 1) || bus.rsp_rd_valid !== 4'b0010 || bus.rsp_rd_data !== x) begin
      errors++; $display("FAIL full_release: got out %0d valid %0h exp %0d 2", bus.rd_outstanding, bus.rsp_rd_valid, TD - 1); end
    @(negedge clk);
    checks++; if (bus.req_rd_ready !== 4'b0010) begin errors++; $display("FAIL full_regrant: got %0h exp 2", bus.req_rd_ready); end
    tick();
    checks++; if (bus.rd_outstanding !== CW'(TD) || bus.ram_rd_en !== 1'b1) begin
      errors++; $display("FAIL full_refill: got out %0d en %0b exp %0d 1", bus.rd_outstanding, bus.ram_rd_en, TD); end
    rd_en = '0; wr_en = '0;
  endtask

  task automatic test_orphan();
    apply_reset();
    ram_rd_valid = 1'b1; ram_rd_data = {9{16'hBEEF}};
    tick();
    ram_rd_valid = 1'b0;
    checks++; if (bus.rsp_rd_valid !== '0 || bus.rsp_rd_data !== '0) begin
      errors++; $display("FAIL orphan_rsp: got valid %0h exp 0, data dropped", bus.rsp_rd_valid); end
    checks++; if (bus.err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag: got %0b exp 1", bus.err_orphan); end
    repeat (5) tick();
    checks++; if (bus.err_orphan !== 1'b1 || bus.rd_outstanding !== '0) begin
      errors++; $display("FAIL orphan_sticky: got %0b out %0d exp 1 0", bus.err_orphan, bus.rd_outstanding); end
    rst = 1'b1;
    #1;
    checks++; if (bus.err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear: got %0b exp 0", bus.err_orphan); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wr_en = 4'b0010;
    @(negedge clk);
    checks++; if (bus.req_wr_ready !== 4'b0010) begin errors++; $display("FAIL mid_wr_ready: got %0h exp 2", bus.req_wr_ready); end
    tick();
    wr_en = '0;
    rd_en = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (bus.req_rd_ready !== 4'b0100) begin errors++; $display("FAIL mid_rd_ready[%0d]: got %0h exp 4", k, bus.req_rd_ready); end
      tick();
    end
    rd_en = '0;
    checks++; if (bus.rd_outstanding !== CW'(5) || bus.ram_rd_en !== 1'b1) begin
      errors++; $display("FAIL mid_outstanding: got %0d en %0b exp 5 1", bus.rd_outstanding, bus.ram_rd_en); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.rd_outstanding !== '0 || bus.ram_rd_en !== 1'b0 || bus.ram_rd_addr !== '0 ||
                  bus.ram_wr_addr !== '0 || bus.rsp_rd_valid !== '0 || bus.err_orphan !== 1'b0) begin
      errors++; $display("FAIL mid_async_reset: got out %0d rd_en %0b rd_addr %0h exp all 0", bus.rd_outstanding, bus.ram_rd_en, bus.ram_rd_addr); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ram_rd_valid = 1'b1; ram_rd_data = DW'(32'hC0 + k);
      tick();
      checks++; if (bus.rsp_rd_valid !== '0) begin errors++; $display("FAIL mid_stale_rsp[%0d]: got %0h exp 0", k, bus.rsp_rd_valid); end
    end
    ram_rd_valid = 1'b0;
    checks++; if (bus.err_orphan !== 1'b1 || bus.rd_outstanding !== '0) begin
      errors++; $display("FAIL mid_stale_orphan: got %0b out %0d exp 1 0", bus.err_orphan, bus.rd_outstanding); end
    wr_en = 4'hF; rd_en = 4'hF;
    @(negedge clk);
    checks++; if (bus.req_wr_ready !== 4'b0001 || bus.req_rd_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_ptr_restart: got wr %0h rd %0h exp 1 1", bus.req_wr_ready, bus.req_rd_ready); end
    tick();
    wr_en = '0; rd_en = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wr_round_robin();
    test_rd_interleave();
    test_full();
    test_orphan();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
